// File: rtl/sat_state_pkg.sv
// Shared encodings and types for the SAT engine per-variable state store.
// Optional feature macro used by the design: BKT_PARALLEL_EN.
package sat_state_pkg;

  // Per-variable value field: {implied, val[1:0]}
  localparam int WIDTH_VAL   = 3;
  localparam int IMPLIED_BIT = 2;

  localparam logic [1:0] VAL_FREE  = 2'b00;
  localparam logic [1:0] VAL_FALSE = 2'b01;
  localparam logic [1:0] VAL_TRUE  = 2'b10;

  // Backtrack controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } bkt_state_e;

  // Build a value field from the implied flag and a polarity code
  function automatic logic [WIDTH_VAL-1:0] make_value(input logic implied,
                                                      input logic [1:0] pol);
    logic [WIDTH_VAL-1:0] v;
    v              = {1'b0, pol};
    v[IMPLIED_BIT] = implied;
    return v;
  endfunction

endpackage

// File: rtl/var_state_cell.sv
// One variable's value and level registers.
// Priority inside the cell: rst, bulk load, backtrack clear, write.
module var_state_cell
  import sat_state_pkg::*;
#(
  parameter int WIDTH_LVL = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load_en,
  input  logic [WIDTH_VAL-1:0] i_load_val,
  input  logic [WIDTH_LVL-1:0] i_load_lvl,
  input  logic                 i_clr,
  input  logic                 i_wr_en,
  input  logic [WIDTH_VAL-1:0] i_wr_val,
  input  logic [WIDTH_LVL-1:0] i_wr_lvl,
  output logic [WIDTH_VAL-1:0] o_val,
  output logic [WIDTH_LVL-1:0] o_lvl,
  output logic                 o_free
);

  logic [WIDTH_VAL-1:0] r_val;
  logic [WIDTH_LVL-1:0] r_lvl;

  // Value/level storage with load, clear and write paths
  always_ff @(posedge clk) begin
    if (rst) begin
      r_val <= {WIDTH_VAL{1'b0}};
      r_lvl <= {WIDTH_LVL{1'b0}};
    end else if (i_load_en) begin
      r_val <= i_load_val;
      r_lvl <= i_load_lvl;
    end else if (i_clr) begin
      r_val <= {WIDTH_VAL{1'b0}};
      r_lvl <= {WIDTH_LVL{1'b0}};
    end else if (i_wr_en) begin
      r_val <= i_wr_val;
      r_lvl <= i_wr_lvl;
    end else begin
      r_val <= r_val;
      r_lvl <= r_lvl;
    end
  end

  assign o_val  = r_val;
  assign o_lvl  = r_lvl;
  assign o_free = (r_val[1:0] == VAL_FREE);

endmodule

// File: rtl/var_state_update.sv
// Per-variable assignment store: decision/implication writes, bulk load and
// backtrack clearing. Values are fed back to the decision stage.
// Optional macro BKT_PARALLEL_EN: backtrack clears all qualifying variables
// in one SCAN cycle instead of walking them one per cycle.
module var_state_update
  import sat_state_pkg::*;
#(
  parameter int NUM_VARS  = 8,
  parameter int WIDTH_LVL = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_en_i,
  input  logic [NUM_VARS*WIDTH_VAL-1:0]  load_values_i,
  input  logic [NUM_VARS*WIDTH_LVL-1:0]  load_lvls_i,
  input  logic                           decision_done_i,
  input  logic [NUM_VARS-1:0]            index_decided_i,
  input  logic [WIDTH_LVL-1:0]           cur_lvl_i,
  input  logic                           imply_valid_i,
  input  logic [NUM_VARS-1:0]            imply_index_i,
  input  logic                           imply_value_i,
  input  logic [WIDTH_LVL-1:0]           imply_lvl_i,
  input  logic                           apply_bkt_i,
  input  logic [WIDTH_LVL-1:0]           bkt_lvl_i,
  output logic [NUM_VARS*WIDTH_VAL-1:0]  vars_value_o,
  output logic [NUM_VARS*WIDTH_LVL-1:0]  vars_lvl_o,
  output logic                           all_assigned_o,
  output logic                           bkt_busy_o,
  output logic                           bkt_done_o,
  output logic                           drop_err_o
);

`ifndef BKT_PARALLEL_EN
  localparam int CNT_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VARS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
`endif

  bkt_state_e           r_state;
  bkt_state_e           w_state_nxt;
  logic [WIDTH_LVL-1:0] r_bkt_lvl;
  logic [WIDTH_LVL-1:0] w_bkt_lvl_nxt;
  logic                 r_bkt_busy;
  logic                 r_bkt_done;
  logic                 r_drop_err;
  logic                 w_drop_set;
  logic                 w_wr_ok;
  logic [NUM_VARS-1:0]  w_free;

  // Writes are blocked during a scan and by a backtrack request that wins priority
  assign w_wr_ok    = (r_state != ST_SCAN) && !apply_bkt_i;
  assign w_drop_set = (r_state == ST_SCAN) && (decision_done_i || imply_valid_i);

  // Backtrack FSM next-state, level latch and scan counter
  always_comb begin
    w_state_nxt   = r_state;
    w_bkt_lvl_nxt = r_bkt_lvl;
`ifndef BKT_PARALLEL_EN
    w_cnt_nxt     = r_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (apply_bkt_i) begin
          w_state_nxt   = ST_SCAN;
          w_bkt_lvl_nxt = bkt_lvl_i;
`ifndef BKT_PARALLEL_EN
          w_cnt_nxt     = {CNT_W{1'b0}};
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
`ifdef BKT_PARALLEL_EN
        w_state_nxt = ST_DONE;
`else
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`endif
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, latched level, counter and status flags; load aborts a scan
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bkt_lvl  <= {WIDTH_LVL{1'b0}};
`ifndef BKT_PARALLEL_EN
      r_cnt      <= {CNT_W{1'b0}};
`endif
      r_bkt_busy <= 1'b0;
      r_bkt_done <= 1'b0;
      r_drop_err <= 1'b0;
    end else if (load_en_i) begin
      r_state    <= ST_IDLE;
      r_bkt_busy <= 1'b0;
      r_bkt_done <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bkt_lvl  <= w_bkt_lvl_nxt;
`ifndef BKT_PARALLEL_EN
      r_cnt      <= w_cnt_nxt;
`endif
      r_bkt_busy <= (w_state_nxt == ST_SCAN);
      r_bkt_done <= (w_state_nxt == ST_DONE);
      r_drop_err <= r_drop_err | w_drop_set;
    end
  end

  for (genvar k = 0; k < NUM_VARS; k++) begin : g_cell
    logic                 w_dec_wr;
    logic                 w_imp_wr;
    logic                 w_clr;
    logic [WIDTH_VAL-1:0] w_wr_val;
    logic [WIDTH_LVL-1:0] w_wr_lvl;
    logic [WIDTH_VAL-1:0] w_val;
    logic [WIDTH_LVL-1:0] w_lvl;

    assign w_dec_wr = w_wr_ok && decision_done_i && index_decided_i[k];
    assign w_imp_wr = w_wr_ok && imply_valid_i && imply_index_i[k];
    // A decision to the same variable overrides the implication
    assign w_wr_val = w_dec_wr ? make_value(1'b0, VAL_FALSE)
                               : make_value(1'b1, imply_value_i ? VAL_TRUE : VAL_FALSE);
    assign w_wr_lvl = w_dec_wr ? cur_lvl_i : imply_lvl_i;

`ifdef BKT_PARALLEL_EN
    assign w_clr = (r_state == ST_SCAN) && !w_free[k] && (w_lvl > r_bkt_lvl);
`else
    assign w_clr = (r_state == ST_SCAN) && (r_cnt == CNT_W'(k)) &&
                   !w_free[k] && (w_lvl > r_bkt_lvl);
`endif

    var_state_cell #(
      .WIDTH_LVL (WIDTH_LVL)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .i_load_en  (load_en_i),
      .i_load_val (load_values_i[k*WIDTH_VAL +: WIDTH_VAL]),
      .i_load_lvl (load_lvls_i[k*WIDTH_LVL +: WIDTH_LVL]),
      .i_clr      (w_clr),
      .i_wr_en    (w_dec_wr || w_imp_wr),
      .i_wr_val   (w_wr_val),
      .i_wr_lvl   (w_wr_lvl),
      .o_val      (w_val),
      .o_lvl      (w_lvl),
      .o_free     (w_free[k])
    );

    assign vars_value_o[k*WIDTH_VAL +: WIDTH_VAL] = w_val;
    assign vars_lvl_o[k*WIDTH_LVL +: WIDTH_LVL]   = w_lvl;
  end

  assign all_assigned_o = &(~w_free);
  assign bkt_busy_o     = r_bkt_busy;
  assign bkt_done_o     = r_bkt_done;
  assign drop_err_o     = r_drop_err;

endmodule

// File: tb/tb_var_state_update.sv
// Directed bench for var_state_update with a transaction-level reference
// model compared every cycle. Honours BKT_PARALLEL_EN when defined.
module tb_var_state_update;

  localparam int NV = 8;
  localparam int WL = 16;
  localparam int WV = 3;

`ifdef BKT_PARALLEL_EN
  localparam int EXP_DONE_AT  = 2;
  localparam int EXP_BUSY_CNT = 1;
`else
  localparam int EXP_DONE_AT  = 9;
  localparam int EXP_BUSY_CNT = 8;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              load_en_i;
  logic [NV*WV-1:0]  load_values_i;
  logic [NV*WL-1:0]  load_lvls_i;
  logic              decision_done_i;
  logic [NV-1:0]     index_decided_i;
  logic [WL-1:0]     cur_lvl_i;
  logic              imply_valid_i;
  logic [NV-1:0]     imply_index_i;
  logic              imply_value_i;
  logic [WL-1:0]     imply_lvl_i;
  logic              apply_bkt_i;
  logic [WL-1:0]     bkt_lvl_i;
  logic [NV*WV-1:0]  vars_value_o;
  logic [NV*WL-1:0]  vars_lvl_o;
  logic              all_assigned_o;
  logic              bkt_busy_o;
  logic              bkt_done_o;
  logic              drop_err_o;

  always #5 clk = ~clk;

  var_state_update #(.NUM_VARS(NV), .WIDTH_LVL(WL)) dut (
    .clk             (clk),
    .rst             (rst),
    .load_en_i       (load_en_i),
    .load_values_i   (load_values_i),
    .load_lvls_i     (load_lvls_i),
    .decision_done_i (decision_done_i),
    .index_decided_i (index_decided_i),
    .cur_lvl_i       (cur_lvl_i),
    .imply_valid_i   (imply_valid_i),
    .imply_index_i   (imply_index_i),
    .imply_value_i   (imply_value_i),
    .imply_lvl_i     (imply_lvl_i),
    .apply_bkt_i     (apply_bkt_i),
    .bkt_lvl_i       (bkt_lvl_i),
    .vars_value_o    (vars_value_o),
    .vars_lvl_o      (vars_lvl_o),
    .all_assigned_o  (all_assigned_o),
    .bkt_busy_o      (bkt_busy_o),
    .bkt_done_o      (bkt_done_o),
    .drop_err_o      (drop_err_o)
  );

  // Reference model: values/levels per variable plus backtrack progress.
  // m_age: -1 idle, 0..NV-1 scan position still to visit, NV = done cycle.
  logic [2:0]  m_val [NV];
  logic [WL-1:0] m_lvl [NV];
  int          m_age;
  logic [WL-1:0] m_blvl;
  logic        m_drop;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic void model_writes();
    for (int k = 0; k < NV; k++) begin
      if (imply_valid_i && imply_index_i[k]) begin
        m_val[k] = imply_value_i ? 3'b110 : 3'b101;
        m_lvl[k] = imply_lvl_i;
      end
    end
    for (int k = 0; k < NV; k++) begin
      if (decision_done_i && index_decided_i[k]) begin
        m_val[k] = 3'b001;
        m_lvl[k] = cur_lvl_i;
      end
    end
  endfunction

  function automatic void model_clear(input int k);
    if (m_val[k][1:0] != 2'b00 && m_lvl[k] > m_blvl) begin
      m_val[k] = 3'b000;
      m_lvl[k] = '0;
    end
  endfunction

  function automatic void model_step();
    if (rst) begin
      for (int k = 0; k < NV; k++) begin m_val[k] = 3'b000; m_lvl[k] = '0; end
      m_age = -1; m_blvl = '0; m_drop = 1'b0;
    end else if (load_en_i) begin
      for (int k = 0; k < NV; k++) begin
        m_val[k] = load_values_i[k*WV +: WV];
        m_lvl[k] = load_lvls_i[k*WL +: WL];
      end
      m_age = -1; m_drop = 1'b0;
    end else if (m_age >= 0 && m_age < NV) begin
      if (decision_done_i || imply_valid_i) m_drop = 1'b1;
`ifdef BKT_PARALLEL_EN
      for (int k = 0; k < NV; k++) model_clear(k);
      m_age = NV;
`else
      model_clear(m_age);
      m_age++;
`endif
    end else if (m_age == NV) begin
      m_age = -1;
      if (!apply_bkt_i) model_writes();
    end else begin
      if (apply_bkt_i) begin
        m_age = 0; m_blvl = bkt_lvl_i;
      end else begin
        model_writes();
      end
    end
  endfunction

  task automatic compare_all();
    logic [NV*WV-1:0] ev;
    logic [NV*WL-1:0] el;
    logic ea;
    ea = 1'b1;
    for (int k = 0; k < NV; k++) begin
      ev[k*WV +: WV] = m_val[k];
      el[k*WL +: WL] = m_lvl[k];
      if (m_val[k][1:0] == 2'b00) ea = 1'b0;
    end
    check("values",       128'(vars_value_o),   128'(ev));
    check("levels",       128'(vars_lvl_o),     128'(el));
    check("all_assigned", 128'(all_assigned_o), 128'(ea));
    check("bkt_busy",     128'(bkt_busy_o),     128'(m_age >= 0 && m_age < NV));
    check("bkt_done",     128'(bkt_done_o),     128'(m_age == NV));
    check("drop_err",     128'(drop_err_o),     128'(m_drop));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    load_en_i = 1'b0; decision_done_i = 1'b0; imply_valid_i = 1'b0;
    apply_bkt_i = 1'b0; index_decided_i = '0; imply_index_i = '0;
  endtask

  int busy_cnt;
  int done_at;
  int done_cnt;

  initial begin
    rst = 1'b1; load_values_i = '0; load_lvls_i = '0; cur_lvl_i = '0;
    imply_value_i = 1'b0; imply_lvl_i = '0; bkt_lvl_i = '0;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    check("reset_values", 128'(vars_value_o), 128'h0);
    check("reset_flags", 128'({all_assigned_o, bkt_busy_o, bkt_done_o, drop_err_o}), 128'h0);

    // Single decision on var2 at level 3
    decision_done_i = 1'b1; index_decided_i = 8'h04; cur_lvl_i = 16'd3;
    tick(); idle_inputs();
    check("dec_var2_value", 128'(vars_value_o), 128'h000040);
    check("dec_var2_level", 128'(vars_lvl_o), 128'h0000_0000_0000_0000_0000_0003_0000_0000);

    // Decision on var0 with implication on var3 in the same cycle
    decision_done_i = 1'b1; index_decided_i = 8'h01; cur_lvl_i = 16'd3;
    imply_valid_i = 1'b1; imply_index_i = 8'h08; imply_value_i = 1'b1; imply_lvl_i = 16'd3;
    tick(); idle_inputs();
    check("dec_imp_both", 128'(vars_value_o), 128'h000C41);

    // Same-variable conflict, then all-zero index strobes
    decision_done_i = 1'b1; index_decided_i = 8'h10; cur_lvl_i = 16'd5;
    imply_valid_i = 1'b1; imply_index_i = 8'h10; imply_value_i = 1'b1; imply_lvl_i = 16'd6;
    tick(); idle_inputs();
    check("conflict_var4", 128'(vars_value_o[14:12]), 128'h1);
    decision_done_i = 1'b1; imply_valid_i = 1'b1;
    tick(); idle_inputs();

    // Assign var k at level k, then backtrack to level 4
    for (int k = 0; k < NV; k++) begin
      decision_done_i = 1'b1; index_decided_i = NV'(1) << k; cur_lvl_i = WL'(k);
      tick();
    end
    idle_inputs();
    check("all_assigned_hi", 128'(all_assigned_o), 128'h1);
    check("all_dec_values", 128'(vars_value_o), 128'h249249);
    apply_bkt_i = 1'b1; bkt_lvl_i = 16'd4;
    busy_cnt = 0; done_at = 0;
    for (int n = 1; n <= 20; n++) begin
      tick(); apply_bkt_i = 1'b0;
      if (bkt_busy_o) busy_cnt++;
      if (bkt_done_o && done_at == 0) done_at = n;
    end
    check("bkt_busy_cycles", 128'(busy_cnt), 128'(EXP_BUSY_CNT));
    check("bkt_done_cycle", 128'(done_at), 128'(EXP_DONE_AT));
    check("bkt4_values", 128'(vars_value_o), 128'h001249);
    check("bkt4_levels", 128'(vars_lvl_o), 128'h0000_0000_0000_0004_0003_0002_0001_0000);

    // Backtrack to 1 with a same-cycle decision (ignored) and one during scan (dropped)
    apply_bkt_i = 1'b1; bkt_lvl_i = 16'd1;
    decision_done_i = 1'b1; index_decided_i = 8'h80; cur_lvl_i = 16'd9;
    tick(); idle_inputs();
    decision_done_i = 1'b1; index_decided_i = 8'h40; cur_lvl_i = 16'd2;
    tick(); idle_inputs();
    for (int n = 0; n < 12; n++) tick();
    check("drop_err_sticky", 128'(drop_err_o), 128'h1);
    check("bkt1_values", 128'(vars_value_o), 128'h000009);

    // Load: even vars true at level 0, odd vars implied-true at level k
    for (int k = 0; k < NV; k++) begin
      load_values_i[k*WV +: WV] = (k % 2 == 0) ? 3'b010 : 3'b110;
      load_lvls_i[k*WL +: WL]   = (k % 2 == 0) ? WL'(0) : WL'(k);
    end
    load_en_i = 1'b1;
    tick(); idle_inputs();
    check("drop_err_cleared", 128'(drop_err_o), 128'h0);
    check("load_all_assigned", 128'(all_assigned_o), 128'h1);
    apply_bkt_i = 1'b1; bkt_lvl_i = 16'd0;
    tick(); idle_inputs();
    for (int n = 0; n < 12; n++) tick();
    check("bkt0_values", 128'(vars_value_o), 128'h082082);
    check("bkt0_all_assigned", 128'(all_assigned_o), 128'h0);

    // Load aborts a running scan without a done pulse
    apply_bkt_i = 1'b1; bkt_lvl_i = 16'd0;
    tick(); idle_inputs();
    tick();
    for (int k = 0; k < NV; k++) begin
      load_values_i[k*WV +: WV] = 3'b001;
      load_lvls_i[k*WL +: WL]   = 16'd2;
    end
    load_en_i = 1'b1;
    tick(); idle_inputs();
    done_cnt = 0;
    for (int n = 0; n < 12; n++) begin tick(); if (bkt_done_o) done_cnt++; end
    check("abort_no_done", 128'(done_cnt), 128'h0);
    check("abort_values", 128'(vars_value_o), 128'h249249);

    // Reset during a scan
    apply_bkt_i = 1'b1; bkt_lvl_i = 16'd0;
    tick(); idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_values", 128'(vars_value_o), 128'h0);
    check("rst_mid_busy", 128'(bkt_busy_o), 128'h0);
    done_cnt = 0;
    for (int n = 0; n < 12; n++) begin tick(); if (bkt_done_o) done_cnt++; end
    check("rst_mid_no_done", 128'(done_cnt), 128'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
